// File: rtl/scan_pkg.sv
// Shared definitions for the scan-bank reader and the writer-side manager.
// Holds the bank geometry, the reader FSM state type and a bank-index helper.
package scan_pkg;

  localparam int unsigned NUM_BANKS   = 6;
  localparam int unsigned BANK_ADDR_W = 10;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BANK_IDX_W  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StRelease
  } scan_state_e;

  // Banks are visited 0..NUM_BANKS-1 and then wrap back to 0.
  function automatic logic [BANK_IDX_W-1:0] next_bank(input logic [BANK_IDX_W-1:0] b);
    return (b == BANK_IDX_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO used as the reader's output buffer.
// Ports:
//   clk_in, rst_in   - clock and synchronous active-high reset
//   push_in/wdata_in - write one entry (ignored when full)
//   pop_in           - remove the head entry (ignored when empty)
//   rdata_out        - head entry, forced to zero while empty
//   count_out        - number of stored entries
//   empty_out/full_out
module word_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] rdata_out,
  output logic [CNT_W-1:0] count_out,
  output logic             empty_out,
  output logic             full_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == CNT_W'(DEPTH));
  assign count_out = count_q;
  assign rdata_out = empty_out ? '0 : mem_q[rptr_q];

  always_comb begin
    do_push = push_in && !full_out;
    do_pop  = pop_in && !empty_out;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_in;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (do_pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/scan_bank_reader.sv
// Reads completed sample banks out in write order (0..5, wrapping) and streams
// each bank's words over a valid/ready interface, then releases the bank.
// Optional feature: define SCAN_BANK_TAG_EN to add tag_out (source bank index
// travelling with each word through the output FIFO).
// Ports:
//   clk_in, rst_in    - clock and synchronous active-high reset
//   bank_full_in      - per-bank pulse: bank completely written
//   rd_bank_out       - bank currently being read
//   rd_addr_out       - port-B read address
//   rd_data_in        - port-B data, READ_LATENCY cycles after the address
//   data_out/valid_out/ready_in/last_out - output stream, last on final word
//   bank_release_out  - per-bank pulse once a bank is fully delivered
//   overflow_out      - sticky: a bank was refilled while still pending
//   tag_out           - (SCAN_BANK_TAG_EN only) source bank of data_out
module scan_bank_reader
  import scan_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned BANK_DEPTH   = 1024,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_BANKS-1:0]   bank_full_in,
  output logic [BANK_IDX_W-1:0]  rd_bank_out,
  output logic [BANK_ADDR_W-1:0] rd_addr_out,
  input  logic [WORD_W-1:0]      rd_data_in,
  output logic [WORD_W-1:0]      data_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   last_out,
  output logic [NUM_BANKS-1:0]   bank_release_out,
  output logic                   overflow_out
`ifdef SCAN_BANK_TAG_EN
  ,
  output logic [BANK_IDX_W-1:0]  tag_out
`endif
);

`ifdef SCAN_BANK_TAG_EN
  localparam int unsigned TagW = BANK_IDX_W;
`else
  localparam int unsigned TagW = 0;
`endif
  localparam int unsigned FifoW = WORD_W + 1 + TagW;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW  = $clog2(READ_LATENCY + FIFO_DEPTH + 1);

  scan_state_e state_q, state_d;

  logic [NUM_BANKS-1:0]   pending_q, pending_d;
  logic [BANK_IDX_W-1:0]  cur_bank_q, cur_bank_d;
  logic [BANK_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0] last_pipe_q, last_pipe_d;
  logic                   overflow_q, overflow_d;

  logic                   issue, release_en, addr_at_end;
  logic [NUM_BANKS-1:0]   release_mask;
  logic [OccW-1:0]        in_flight, occupancy;

  logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CntW-1:0]        fifo_count;
  logic [FifoW-1:0]       fifo_wdata, fifo_rdata;

  assign addr_at_end = (rd_addr_q == BANK_ADDR_W'(BANK_DEPTH - 1));

  // Reads issued but not yet returned.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + OccW'(vld_pipe_q[i]);
    end
  end

  // Every outstanding read already owns a FIFO slot, so returning data can
  // always be pushed regardless of how long the consumer stalls.
  assign occupancy = in_flight + OccW'(fifo_count);

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pending_q[cur_bank_q]) state_d = StScan;
      StScan:    if (issue && addr_at_end) state_d = StDrain;
      StDrain:   if ((in_flight == '0) && fifo_empty) state_d = StRelease;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    issue      = 1'b0;
    release_en = 1'b0;
    unique case (state_q)
      StScan:    issue = (occupancy < OccW'(FIFO_DEPTH));
      StRelease: release_en = 1'b1;
      default:   ;
    endcase
  end

  // Datapath next state
  always_comb begin
    release_mask = release_en ? (NUM_BANKS'(1) << cur_bank_q) : '0;
    // A new full pulse wins over a simultaneous release of the same bank.
    pending_d    = (pending_q & ~release_mask) | bank_full_in;
    overflow_d   = overflow_q | (|(bank_full_in & pending_q));
    cur_bank_d   = release_en ? next_bank(cur_bank_q) : cur_bank_q;

    rd_addr_d = rd_addr_q;
    if (state_q == StIdle) begin
      rd_addr_d = '0;
    end else if (issue) begin
      rd_addr_d = addr_at_end ? '0 : rd_addr_q + 1'b1;
    end

    vld_pipe_d[0]  = issue;
    last_pipe_d[0] = issue && addr_at_end;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending_q   <= '0;
      cur_bank_q  <= '0;
      rd_addr_q   <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      cur_bank_q  <= cur_bank_d;
      rd_addr_q   <= rd_addr_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      overflow_q  <= overflow_d;
    end
  end

  assign fifo_push = vld_pipe_q[READ_LATENCY-1];
  assign fifo_pop  = ready_in;

  // cur_bank_q cannot change while reads are outstanding (release waits for
  // the drain), so it is the correct source tag at push time.
`ifdef SCAN_BANK_TAG_EN
  assign fifo_wdata = {cur_bank_q, last_pipe_q[READ_LATENCY-1], rd_data_in};
  assign tag_out    = fifo_rdata[FifoW-1 -: BANK_IDX_W];
`else
  assign fifo_wdata = {last_pipe_q[READ_LATENCY-1], rd_data_in};
`endif

  word_fifo #(
    .WIDTH (FifoW),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (fifo_push),
    .wdata_in  (fifo_wdata),
    .pop_in    (fifo_pop),
    .rdata_out (fifo_rdata),
    .count_out (fifo_count),
    .empty_out (fifo_empty),
    .full_out  (fifo_full)
  );

  assign rd_bank_out      = cur_bank_q;
  assign rd_addr_out      = rd_addr_q;
  assign data_out         = fifo_rdata[WORD_W-1:0];
  assign last_out         = fifo_rdata[WORD_W];
  assign valid_out        = !fifo_empty;
  assign bank_release_out = release_mask;
  assign overflow_out     = overflow_q;

  no_fifo_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(fifo_push && fifo_full && !ready_in));

endmodule

// File: tb/tb_scan_bank_reader.sv
module tb_scan_bank_reader;
  import scan_pkg::*;

  localparam int unsigned L = 2;
  localparam int unsigned D = 1024;
  localparam int unsigned F = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [5:0]  bank_full_in;
  logic [2:0]  rd_bank_out;
  logic [9:0]  rd_addr_out;
  logic [31:0] rd_data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        last_out;
  logic [5:0]  bank_release_out;
  logic        overflow_out;
`ifdef SCAN_BANK_TAG_EN
  logic [2:0]  tag_out;
`endif

  scan_bank_reader #(
    .READ_LATENCY (L),
    .BANK_DEPTH   (D),
    .FIFO_DEPTH   (F)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .bank_full_in     (bank_full_in),
    .rd_bank_out      (rd_bank_out),
    .rd_addr_out      (rd_addr_out),
    .rd_data_in       (rd_data_in),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .ready_in         (ready_in),
    .last_out         (last_out),
    .bank_release_out (bank_release_out),
    .overflow_out     (overflow_out)
`ifdef SCAN_BANK_TAG_EN
    ,
    .tag_out          (tag_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bank memory: contents are a function of bank, address and a per-fill salt.
  logic [15:0] salt [6];

  function automatic logic [31:0] mem_word(input int b, input int a);
    return {salt[b], 3'(b), 3'b000, 10'(a)};
  endfunction

  logic [31:0] mem_pipe [L];
  always @(posedge clk_in) begin
    mem_pipe[0] <= mem_word(int'(rd_bank_out), int'(rd_addr_out));
    for (int i = 1; i < L; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign rd_data_in = mem_pipe[L-1];

  // Consumer
  int ready_pct = 100;
  always @(posedge clk_in) begin
    #1 ready_in = ($urandom_range(99) < ready_pct);
  end

  // Reference model: banks are delivered in order 0..5 with addresses 0..D-1.
  int cyc = 0;
  int exp_bank, exp_addr, bank_done, n_rel, rel_bank, last_xfer_cyc, xfer_total;
  bit stalled_prev;
  logic [31:0] held_data;
  logic held_last;

  task automatic model_reset();
    exp_bank = 0; exp_addr = 0; bank_done = 0; n_rel = 0; rel_bank = 0;
    last_xfer_cyc = 0; xfer_total = 0; stalled_prev = 0;
  endtask

  always @(negedge clk_in) begin
    cyc++;
    if (!rst_in) begin
      check_eq("fifo_bound", 32'(dut.fifo_count <= F), 1);
      if (stalled_prev) begin
        check_eq("hold_valid", 32'(valid_out), 1);
        check_eq("hold_data", data_out, held_data);
        check_eq("hold_last", 32'(last_out), 32'(held_last));
      end
      if (valid_out && ready_in) begin
        check_eq("data", data_out, mem_word(exp_bank, exp_addr));
        check_eq("last", 32'(last_out), 32'(exp_addr == D - 1));
`ifdef SCAN_BANK_TAG_EN
        check_eq("tag", 32'(tag_out), exp_bank);
`endif
        last_xfer_cyc = cyc;
        xfer_total++;
        exp_addr++;
        if (exp_addr == D) begin
          exp_addr  = 0;
          exp_bank  = (exp_bank + 1) % 6;
          bank_done++;
        end
      end
      stalled_prev = valid_out && !ready_in;
      held_data    = data_out;
      held_last    = last_out;
      if (bank_release_out != 6'b0) begin
        check_eq("release_bank", 32'(bank_release_out), 32'(1) << rel_bank);
        check_eq("release_complete", 32'(bank_done > n_rel), 1);
        check_eq("release_gap", cyc - last_xfer_cyc, 2);
        n_rel++;
        rel_bank = (rel_bank + 1) % 6;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    bank_full_in = '0;
    repeat (3) tick();
    model_reset();
    rst_in = 1'b0;
  endtask

  task automatic pulse(input int b, input bit refresh);
    if (refresh) salt[b] = 16'($urandom);
    bank_full_in = 6'(1) << b;
    tick();
    bank_full_in = '0;
  endtask

  task automatic wait_rel(input int n, input int budget);
    int k = 0;
    while (n_rel < n && k < budget) begin
      tick();
      k++;
    end
    check_eq("release_count", n_rel, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    for (int b = 0; b < 6; b++) salt[b] = 16'($urandom);
    ready_in = 1'b1;
    model_reset();
    do_reset();

    // Reset state
    check_eq("rst_valid", 32'(valid_out), 0);
    check_eq("rst_last", 32'(last_out), 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_addr", 32'(rd_addr_out), 0);
    check_eq("rst_bank", 32'(rd_bank_out), 0);
    check_eq("rst_release", 32'(bank_release_out), 0);
    check_eq("rst_overflow", 32'(overflow_out), 0);

    // Single bank, full-rate consumer, first-word latency
    ready_pct = 100;
    pulse(0, 1);
    k = 1;
    while (!valid_out && k < 100) begin
      tick();
      k++;
    end
    check_eq("first_word_latency", k, L + 3);
    wait_rel(1, 3000);
    check_eq("bank0_words", xfer_total, D);
    check_eq("bank0_overflow", 32'(overflow_out), 0);

    // Bank 1 ready before bank 0: nothing read until bank 0 arrives
    do_reset();
    pulse(1, 1);
    k = 0;
    repeat (40) begin
      tick();
      if (valid_out || rd_addr_out != 0) k++;
    end
    check_eq("wait_for_bank0", k, 0);
    check_eq("wait_bank_idx", 32'(rd_bank_out), 0);
    pulse(0, 1);
    wait_rel(2, 6000);
    check_eq("order_next_bank", exp_bank, 2);

    // Random 30% consumer on bank 2, with an overflowing refill
    ready_pct = 30;
    pulse(2, 1);
    repeat (20) tick();
    check_eq("ovf_before", 32'(overflow_out), 0);
    pulse(2, 0);
    check_eq("ovf_set", 32'(overflow_out), 1);
    wait_rel(3, 20000);
    check_eq("ovf_sticky", 32'(overflow_out), 1);
    check_eq("bank2_total", xfer_total, 3 * D);

    // Reset in the middle of bank 3
    ready_pct = 100;
    pulse(3, 1);
    k = 0;
    while (!(exp_bank == 3 && exp_addr >= 500) && k < 5000) begin
      tick();
      k++;
    end
    check_eq("reach_word_500", 32'(exp_bank == 3 && exp_addr >= 500), 1);
    rst_in = 1'b1;
    tick();
    check_eq("mid_rst_valid", 32'(valid_out), 0);
    check_eq("mid_rst_release", 32'(bank_release_out), 0);
    check_eq("mid_rst_overflow", 32'(overflow_out), 0);
    tick();
    model_reset();
    rst_in = 1'b0;
    repeat (50) tick();
    check_eq("no_partial_release", n_rel, 0);
    check_eq("post_rst_valid", 32'(valid_out), 0);

    // All six banks back to back, wrap to bank 0
    for (int b = 0; b < 6; b++) pulse(b, 1);
    wait_rel(6, 12000);
    check_eq("wrap_bank", 32'(rd_bank_out), 0);
    check_eq("wrap_model", exp_bank, 0);
    check_eq("six_total", xfer_total, 6 * D);
    repeat (20) tick();
    check_eq("idle_after_wrap", 32'(valid_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_bank_reader.md
SCAN_BANK_READER -- requirements
Module: scan_bank_reader

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 2, meaning cycles from rd_addr_out/rd_bank_out to valid rd_data_in.
REQ-002 The block SHALL have parameter BANK_DEPTH, default 1024, meaning words per bank.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries, with FIFO_DEPTH >= READ_LATENCY + 1.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port bank_full_in, input, 6 bits: one-cycle pulse per bank, marking that bank as completely written.
REQ-007 The block SHALL have port rd_bank_out, output, 3 bits: index (0-5) of the bank being read.
REQ-008 The block SHALL have port rd_addr_out, output, 10 bits: port-B read address.
REQ-009 The block SHALL have port rd_data_in, input, 32 bits: selected bank port-B data, READ_LATENCY cycles after the address.
REQ-010 The block SHALL have port data_out, output, 32 bits: angle/distance word.
REQ-011 The block SHALL have port valid_out, output, 1 bit: data_out is valid.
REQ-012 The block SHALL have port ready_in, input, 1 bit: the consumer accepts the word.
REQ-013 The block SHALL have port last_out, output, 1 bit: the current word is address BANK_DEPTH-1 of its bank.
REQ-014 The block SHALL have port bank_release_out, output, 6 bits: one-cycle pulse when a bank has been fully delivered.
REQ-015 The block SHALL have port overflow_out, output, 1 bit: sticky flag set when a bank is refilled before it was released.

Function
REQ-016 The block SHALL keep a 6-bit pending mask; bank_full_in[i] sets pending[i], and a release of bank i clears it.
REQ-017 If a set and a clear of the same pending bit occur in the same cycle, the set SHALL win.
REQ-018 If bank_full_in[i] arrives while pending[i] is already 1, the block SHALL set overflow_out, which stays set until reset.
REQ-019 Banks SHALL be served strictly in order 0,1,2,3,4,5,0,..., matching the write order; the block waits on the current bank until its pending bit is set.
REQ-020 The state machine SHALL have states IDLE, SCAN, DRAIN and RELEASE.
REQ-021 IDLE SHALL go to SCAN when pending[cur_bank]=1, with rd_addr_out starting at 0.
REQ-022 SCAN SHALL issue a read in a cycle only when in_flight + fifo_count < FIFO_DEPTH, then increment rd_addr_out.
REQ-023 SCAN SHALL go to DRAIN after issuing address BANK_DEPTH-1.
REQ-024 DRAIN SHALL wait until in_flight=0 and the FIFO is empty.
REQ-025 RELEASE SHALL pulse bank_release_out[cur_bank] for one cycle, advance cur_bank modulo 6 (5 wraps to 0), and return to IDLE.
REQ-026 A READ_LATENCY-deep valid/last shift pipeline SHALL tag each issued read; returning data SHALL be pushed into the FIFO.
REQ-027 Issue gating SHALL guarantee the FIFO never overflows and no returning word is ever dropped.
REQ-028 The output SHALL use a valid/ready handshake: a word transfers when valid_out && ready_in.
REQ-029 data_out and last_out SHALL be held stable while valid_out=1 and ready_in=0.
REQ-030 valid_out SHALL be 1 exactly when the FIFO is non-empty.
REQ-031 Exactly BANK_DEPTH words SHALL be delivered per bank, in ascending address order; last_out SHALL be asserted on the final word only.
REQ-032 With ready_in held at 1, sustained throughput SHALL be 1 word per cycle after the initial READ_LATENCY fill.
REQ-033 The first word of a bank SHALL appear on data_out READ_LATENCY+1 cycles after the SCAN entry cycle.

Reset
REQ-034 While rst_in=1, the block SHALL clear the state to IDLE and clear pending, cur_bank, rd_addr_out, rd_bank_out, the in-flight pipeline, the FIFO, valid_out, last_out, data_out, bank_release_out and overflow_out.
REQ-035 On reset mid-scan, reads already in flight SHALL be discarded and no partial release pulse SHALL be generated.

Configuration
REQ-036 When macro SCAN_BANK_TAG_EN is defined, the block SHALL add output port tag_out (3 bits), carrying the source bank index aligned with data_out and stored in the FIFO alongside each word.
REQ-037 When SCAN_BANK_TAG_EN is undefined, port tag_out and its FIFO storage SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-038 The state enum, NUM_BANKS=6, BANK_ADDR_W=10 and WORD_W=32 SHALL be defined in shared package scan_pkg, which the writer-side manager also uses.
REQ-039 The output buffer SHALL be a sub-module named word_fifo: synchronous, FIFO_DEPTH entries, with push, pop, count, empty and full.

Verification
REQ-040 The bench SHALL cover: reset, then a pulse on bank_full_in=6'b000001, ready_in=1 -> 1024 words with addresses 0..1023, last_out on word 1024 only, and bank_release_out=6'b000001 one cycle after DRAIN completes.
REQ-041 The bench SHALL cover: bank 1 full while cur_bank=0 and bank 0 not pending -> no reads until bank 0 is full, then bank 0 is read first, followed by bank 1.
REQ-042 The bench SHALL cover: random ready_in at 30% duty -> no word lost or duplicated, data_out stable while stalled, and fifo_count never exceeding 4.
REQ-043 The bench SHALL cover: a second bank_full_in[2] pulse before bank 2 is released -> overflow_out=1 from the next cycle until reset.
REQ-044 The bench SHALL cover: rst_in asserted at word 500 of bank 3 -> valid_out=0 the next cycle, and no bank_release_out pulse.
REQ-045 The bench SHALL cover: all six banks filled sequentially -> releases in order 0..5 and cur_bank wrapping to 0.
